// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Game-flow controller for the DDR arrow game. Steps the session
//               through IDLE, COUNTDOWN, PLAY, PAUSE and GAMEOVER, owns the
//               lives / level / hit counters and derives the metronome divisor.
// Ports       : clk             - system clock (100 MHz)
//               reset           - synchronous active-high reset
//               start_i         - single-cycle start request
//               pause_sw_i      - level, high requests pause
//               beat_tick_i     - single-cycle pulse once per metronome beat
//               correct_hit_i   - single-cycle pulse from collision logic
//               incorrect_hit_i - single-cycle pulse from collision logic
//               game_state_o    - IDLE=0 COUNTDOWN=1 PLAY=2 PAUSE=3 GAMEOVER=4
//               lives_o         - remaining lives
//               level_o         - current level, 0..MAX_LEVEL
//               beat_div_o      - metronome divisor for the clock module
//               countdown_o     - beats remaining in COUNTDOWN, 0 otherwise
//               play_en_o       - high exactly while game_state_o == PLAY
//               clear_score_o   - one-cycle pulse clearing score and combo
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
   parameter int START_LIVES     = 3,
   parameter int HITS_PER_LEVEL  = 8,
   parameter int MAX_LEVEL       = 7,
   parameter int BASE_DIV        = 100000000,
   parameter int DIV_STEP        = 10000000,
   parameter int COUNTDOWN_BEATS = 3,
   parameter int GAMEOVER_BEATS  = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        pause_sw_i,
   input  logic        beat_tick_i,
   input  logic        correct_hit_i,
   input  logic        incorrect_hit_i,
   output logic [2:0]  game_state_o,
   output logic [2:0]  lives_o,
   output logic [2:0]  level_o,
   output logic [26:0] beat_div_o,
   output logic [1:0]  countdown_o,
   output logic        play_en_o,
   output logic        clear_score_o
);

   localparam int HCW = $clog2(HITS_PER_LEVEL + 1);
   localparam int BCW = $clog2(GAMEOVER_BEATS + 1);

   localparam logic [2:0]     c_START_LIVES = 3'(START_LIVES);
   localparam logic [2:0]     c_MAX_LEVEL   = 3'(MAX_LEVEL);
   localparam logic [26:0]    c_BASE_DIV    = 27'(BASE_DIV);
   localparam logic [26:0]    c_DIV_STEP    = 27'(DIV_STEP);
   localparam logic [1:0]     c_CD_BEATS    = 2'(COUNTDOWN_BEATS);
   localparam logic [HCW-1:0] c_HIT_LAST    = HCW'(HITS_PER_LEVEL - 1);
   localparam logic [BCW-1:0] c_GO_LAST     = BCW'(GAMEOVER_BEATS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_GAMEOVER  = 3'd4
   } state_t;

   state_t         state_q,    state_d;
   logic [2:0]     lives_q,    lives_d;
   logic [2:0]     level_q,    level_d;
   logic [26:0]    beat_div_q, beat_div_d;
   logic [1:0]     cd_q,       cd_d;
   logic           play_en_q,  play_en_d;
   logic           clr_q,      clr_d;
   logic [HCW-1:0] hit_cnt_q,  hit_cnt_d;
   logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
   logic           w_start;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      level_d    = level_q;
      beat_div_d = beat_div_q;
      cd_d       = cd_q;
      hit_cnt_d  = hit_cnt_q;
      beat_cnt_d = beat_cnt_q;
      clr_d      = 1'b0;
      w_start    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) w_start = 1'b1;
         end

         ST_COUNTDOWN: begin
            // Pause freezes the countdown rather than leaving the state.
            if (beat_tick_i && !pause_sw_i) begin
               if (cd_q <= 2'd1) begin
                  cd_d    = 2'd0;
                  state_d = ST_PLAY;
               end else begin
                  cd_d = cd_q - 2'd1;
               end
            end
         end

         ST_PLAY: begin
            // A miss outranks a simultaneous hit; the hit is dropped.
            if (incorrect_hit_i) begin
               if (lives_q <= 3'd1) begin
                  lives_d    = 3'd0;
                  state_d    = ST_GAMEOVER;
                  beat_cnt_d = '0;
               end else begin
                  lives_d = lives_q - 3'd1;
               end
            end else if (correct_hit_i) begin
               if (hit_cnt_q == c_HIT_LAST) begin
                  // At the top level the counter simply wraps.
                  hit_cnt_d = '0;
                  if (level_q < c_MAX_LEVEL) begin
                     level_d    = level_q + 3'd1;
                     beat_div_d = beat_div_q - c_DIV_STEP;
                  end
               end else begin
                  hit_cnt_d = hit_cnt_q + 1'b1;
               end
            end
            // Game over takes precedence over a pause request.
            if (pause_sw_i && (state_d == ST_PLAY)) state_d = ST_PAUSE;
         end

         ST_PAUSE: begin
            if (!pause_sw_i) state_d = ST_PLAY;
         end

         ST_GAMEOVER: begin
            if (start_i) begin
               w_start = 1'b1;
            end else if (beat_tick_i) begin
               if (beat_cnt_q >= c_GO_LAST) begin
                  beat_cnt_d = '0;
                  state_d    = ST_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            // Unused encodings fall back to IDLE.
            state_d    = ST_IDLE;
            cd_d       = 2'd0;
            beat_cnt_d = '0;
         end
      endcase

      // Session start: shared by IDLE and GAMEOVER.
      if (w_start) begin
         state_d    = ST_COUNTDOWN;
         clr_d      = 1'b1;
         lives_d    = c_START_LIVES;
         level_d    = 3'd0;
         beat_div_d = c_BASE_DIV;
         hit_cnt_d  = '0;
         beat_cnt_d = '0;
         cd_d       = c_CD_BEATS;
      end

      play_en_d = (state_d == ST_PLAY);
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         lives_q    <= c_START_LIVES;
         level_q    <= 3'd0;
         beat_div_q <= c_BASE_DIV;
         cd_q       <= 2'd0;
         play_en_q  <= 1'b0;
         clr_q      <= 1'b0;
         hit_cnt_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lives_q    <= lives_d;
         level_q    <= level_d;
         beat_div_q <= beat_div_d;
         cd_q       <= cd_d;
         play_en_q  <= play_en_d;
         clr_q      <= clr_d;
         hit_cnt_q  <= hit_cnt_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign game_state_o  = state_q;
   assign lives_o       = lives_q;
   assign level_o       = level_q;
   assign beat_div_o    = beat_div_q;
   assign countdown_o   = cd_q;
   assign play_en_o     = play_en_q;
   assign clear_score_o = clr_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Self-checking bench for game_sequencer. Each cycle is a record
//               of inputs plus expected outputs; expectations are queued when
//               the inputs are driven and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_i = 1'b0;
   logic        pause_sw_i = 1'b0;
   logic        beat_tick_i = 1'b0;
   logic        correct_hit_i = 1'b0;
   logic        incorrect_hit_i = 1'b0;
   logic [2:0]  game_state_o;
   logic [2:0]  lives_o;
   logic [2:0]  level_o;
   logic [26:0] beat_div_o;
   logic [1:0]  countdown_o;
   logic        play_en_o;
   logic        clear_score_o;

   always #5 clk = ~clk;

   game_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start_i),
      .pause_sw_i      (pause_sw_i),
      .beat_tick_i     (beat_tick_i),
      .correct_hit_i   (correct_hit_i),
      .incorrect_hit_i (incorrect_hit_i),
      .game_state_o    (game_state_o),
      .lives_o         (lives_o),
      .level_o         (level_o),
      .beat_div_o      (beat_div_o),
      .countdown_o     (countdown_o),
      .play_en_o       (play_en_o),
      .clear_score_o   (clear_score_o)
   );

   typedef struct {
      logic       rst, st, ps, bt, ch, ih;
      logic [2:0] e_state, e_lives, e_level;
      logic [1:0] e_cd;
      logic       e_play, e_clr;
   } vec_t;

   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic rst, st, ps, bt, ch, ih,
                               input logic [2:0] s, l, lv,
                               input logic [1:0] cd, input logic pe, cl);
      vec_t r;
      r.rst = rst; r.st = st; r.ps = ps; r.bt = bt; r.ch = ch; r.ih = ih;
      r.e_state = s; r.e_lives = l; r.e_level = lv;
      r.e_cd = cd; r.e_play = pe; r.e_clr = cl;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic compare_out();
      vec_t        e;
      logic [26:0] ediv;
      if (exp_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard: queue empty at %0t", $time);
         return;
      end
      e = exp_q.pop_front();
      ediv = 27'(100000000 - int'(e.e_level) * 10000000);
      chk("game_state",  32'(game_state_o),  32'(e.e_state));
      chk("lives",       32'(lives_o),       32'(e.e_lives));
      chk("level",       32'(level_o),       32'(e.e_level));
      chk("beat_div",    32'(beat_div_o),    32'(ediv));
      chk("countdown",   32'(countdown_o),   32'(e.e_cd));
      chk("play_en",     32'(play_en_o),     32'(e.e_play));
      chk("clear_score", 32'(clear_score_o), 32'(e.e_clr));
   endtask

   // Drive one cycle of inputs, queue its expectation, check after the edge.
   task automatic apply(input vec_t x);
      reset           = x.rst;
      start_i         = x.st;
      pause_sw_i      = x.ps;
      beat_tick_i     = x.bt;
      correct_hit_i   = x.ch;
      incorrect_hit_i = x.ih;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   function automatic logic [2:0] lvl_of(input int base, input int hits);
      int l;
      l = base + hits / 8;
      if (l > 7) l = 7;
      return 3'(l);
   endfunction

   vec_t tbl[$];

   initial begin
      // ---------------- table: reset, idle, countdown ----------------
      //            rst st ps bt ch ih  st  lv lvl cd pe cl
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 3, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 3, 0, 2, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 3, 0, 2, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 2, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 3, 0, 2, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 3, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2, 3, 0, 0, 1, 0));
      foreach (tbl[i]) apply(tbl[i]);

      // ---------------- first level-up ----------------
      for (int i = 1; i <= 8; i++)
         apply(mk(0, 0, 0, 0, 1, 0, 2, 3, lvl_of(0, i), 0, 1, 0));
      // counter to 3, then simultaneous hit + miss: miss wins
      for (int i = 1; i <= 3; i++)
         apply(mk(0, 0, 0, 0, 1, 0, 2, 3, 1, 0, 1, 0));
      apply(mk(0, 0, 0, 0, 1, 1, 2, 2, 1, 0, 1, 0));

      // ---------------- pause: hit on entry still counts ----------------
      apply(mk(0, 0, 1, 0, 1, 0, 3, 2, 1, 0, 0, 0));
      apply(mk(0, 0, 1, 0, 0, 1, 3, 2, 1, 0, 0, 0));
      apply(mk(0, 0, 1, 0, 1, 0, 3, 2, 1, 0, 0, 0));
      apply(mk(0, 1, 1, 1, 0, 0, 3, 2, 1, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 0, 2, 2, 1, 0, 1, 0));
      // counter is 4: level 2 lands exactly on the 4th hit
      for (int i = 1; i <= 4; i++)
         apply(mk(0, 0, 0, 0, 1, 0, 2, 2, (i == 4) ? 3'd2 : 3'd1, 0, 1, 0));

      // ---------------- climb to MAX_LEVEL and saturate ----------------
      for (int i = 1; i <= 48; i++)
         apply(mk(0, (i == 10), 0, 0, 1, 0, 2, 2, lvl_of(2, i), 0, 1, 0));

      // ---------------- lives run out; game over beats pause ----------------
      apply(mk(0, 0, 0, 0, 0, 1, 2, 1, 7, 0, 1, 0));
      apply(mk(0, 0, 1, 0, 0, 1, 4, 0, 7, 0, 0, 0));
      apply(mk(0, 0, 1, 0, 0, 0, 4, 0, 7, 0, 0, 0));
      for (int i = 1; i <= 5; i++)
         apply(mk(0, 0, 0, 1, (i == 2), 0, (i == 5) ? 3'd0 : 3'd4, 0, 7, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 7, 0, 0, 0));

      // ---------------- restart from IDLE ----------------
      apply(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 3, 0, 1));
      apply(mk(0, 0, 0, 1, 0, 0, 1, 3, 0, 2, 0, 0));
      apply(mk(0, 0, 0, 1, 0, 0, 1, 3, 0, 1, 0, 0));
      apply(mk(0, 0, 0, 1, 0, 0, 2, 3, 0, 0, 1, 0));
      apply(mk(0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 1, 0));
      apply(mk(0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 0));
      apply(mk(0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0));
      // start from GAMEOVER wins over a coincident beat
      apply(mk(0, 1, 0, 1, 0, 0, 1, 3, 0, 3, 0, 1));
      apply(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, 0));
      apply(mk(0, 0, 0, 1, 0, 0, 1, 3, 0, 2, 0, 0));
      apply(mk(0, 0, 0, 1, 0, 0, 1, 3, 0, 1, 0, 0));
      apply(mk(0, 0, 0, 1, 0, 0, 2, 3, 0, 0, 1, 0));

      // ---------------- reset mid-PLAY at level 3 ----------------
      for (int i = 1; i <= 24; i++)
         apply(mk(0, 0, 0, 0, 1, 0, 2, 3, lvl_of(0, i), 0, 1, 0));
      apply(mk(1, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller for the DDR arrow game. It sequences the play session through idle, countdown, play, pause and game-over. It owns the lives and level counters and derives the metronome divisor that configures the beat clock. The arrow, score, collision and display modules run from its registered state and enables.

Parameters:
START_LIVES, 3, lives loaded at game start (1..7)
HITS_PER_LEVEL, 8, correct hits needed to advance one level
MAX_LEVEL, 7, highest level (level saturates here)
BASE_DIV, 100000000, metronome divisor at level 0 (1 Hz at 100 MHz)
DIV_STEP, 10000000, divisor reduction per level
COUNTDOWN_BEATS, 3, beats counted down before play (1..3)
GAMEOVER_BEATS, 5, beats held in GAMEOVER before auto-return to IDLE

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle start request (debounced btnR pulse)
pause_sw  in  1  level; high requests pause
beat_tick  in  1  single-cycle pulse in clk domain, once per metronome beat
correct_hit  in  1  single-cycle pulse from collision logic
incorrect_hit  in  1  single-cycle pulse from collision logic
game_state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, GAMEOVER=4
lives  out  3  remaining lives
level  out  3  current level, 0..MAX_LEVEL
beat_div  out  27  metronome divisor for the clock module
countdown  out  2  beats remaining in COUNTDOWN, 0 otherwise
play_en  out  1  high exactly while game_state==PLAY
clear_score  out  1  one-cycle pulse; score and combo clear

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high. All outputs are registered.
- Reset values: game_state=IDLE, lives=START_LIVES, level=0, beat_div=BASE_DIV, countdown=0, play_en=0, clear_score=0. The internal hit counter and beat counter are 0.
- Reset mid-operation: any state returns to the reset values at the next edge. No pulse is emitted.
- IDLE:
  - start=1 moves to COUNTDOWN at the next edge.
  - On that same edge: clear_score=1 for exactly one cycle, lives=START_LIVES, level=0, beat_div=BASE_DIV, hit counter=0, countdown=COUNTDOWN_BEATS.
  - Hits and beats are ignored.
- COUNTDOWN:
  - Each beat_tick with pause_sw=0 decrements countdown.
  - A beat_tick while countdown==1 moves to PLAY and sets countdown=0.
  - While pause_sw=1, beat ticks are ignored (the countdown freezes).
  - start and hits are ignored.
- PLAY:
  - play_en=1 from the first cycle game_state reads PLAY.
  - correct_hit: the hit counter increments.
  - When the counter reaches HITS_PER_LEVEL and level<MAX_LEVEL: level+1, beat_div-=DIV_STEP, counter=0. All three update on the same edge.
  - At MAX_LEVEL the counter wraps to 0 with no level or divisor change.
  - incorrect_hit: lives-1. If lives==1 before the decrement, lives becomes 0 and the state moves to GAMEOVER on the same edge.
  - Simultaneous correct_hit and incorrect_hit: incorrect wins and the correct hit is discarded.
  - pause_sw=1 moves to PAUSE at the next edge. A hit in that same cycle is still processed.
  - If GAMEOVER and pause are both triggered, GAMEOVER wins.
  - start is ignored.
- PAUSE:
  - play_en=0. Hits, beats and start are ignored.
  - pause_sw=0 returns to PLAY at the next edge.
  - lives, level and the hit counter are preserved.
- GAMEOVER:
  - play_en=0. Counts beat_tick pulses.
  - After GAMEOVER_BEATS ticks, moves to IDLE. lives stays 0 and level is held until the next start.
  - start=1 restarts immediately, with the same entry actions as IDLE→COUNTDOWN. It takes priority over the beat count.
- beat_div invariant: beat_div always equals BASE_DIV - level*DIV_STEP. The parameters must keep this value above 0.
- Encodings 5..7 are unreachable. If entered, the block must return to IDLE at the next edge.

Test Plan:
- Reset, then start pulse at cycle 10 → cycle 11: game_state=1, clear_score=1 for one cycle, lives=3, countdown=3. Three beat_ticks → game_state=2, countdown=0, play_en=1.
- In PLAY, 8 correct_hit pulses → level=1, beat_div=90000000. 56 more → level=7, beat_div=30000000. 8 more → level stays 7, beat_div unchanged.
- In PLAY with lives=3: correct_hit and incorrect_hit in the same cycle → lives=2, hit counter unchanged. Two more incorrect_hit → lives=0, game_state=4, play_en=0.
- pause_sw high during PLAY with lives=2, level=1 → game_state=3. Hits ignored (lives stays 2). pause_sw low → game_state=2, values intact.
- GAMEOVER: 5 beat_ticks → game_state=0. Repeat: start pulse after 2 beats → game_state=1, lives=3, level=0, clear_score pulse.
- reset asserted for one cycle during PLAY at level 3 → next edge: game_state=0, level=0, beat_div=100000000, play_en=0, no clear_score pulse.
